// File: rtl/rgb_minmax_ctrl_if.sv
// Pixel-in / result-out bundle for the rgb2hsv min/max sequencing controller.
// The controller uses the slave side; the pixel source and result sink use the master side.
interface rgb_minmax_ctrl_if #(
    parameter int W = 10,
    parameter int U = 2
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_r;
    logic [W-1:0] in_g;
    logic [W-1:0] in_b;
    logic [U-1:0] in_user;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_max;
    logic [W-1:0] out_min;
    logic [W-1:0] out_delta;
    logic [1:0]   out_max_idx;
    logic [1:0]   out_min_idx;
    logic [U-1:0] out_user;
    logic         busy;

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_user, out_ready,
        output in_ready, out_valid, out_max, out_min, out_delta,
               out_max_idx, out_min_idx, out_user, busy
    );

    modport master (
        output in_valid, in_r, in_g, in_b, in_user, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_delta,
               out_max_idx, out_min_idx, out_user, busy
    );
endinterface

// File: rtl/rgb_minmax_ctrl.sv
// Sequences one shared three-input compare-select unit through max then min mode
// per pixel and presents max, min, delta, winning indices and sideband downstream.
module rgb_minmax_ctrl #(
    parameter int W = 10,
    parameter int U = 2
) (
    input  logic              clk,
    input  logic              rst,
    rgb_minmax_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMP_MAX = 2'd1,
        ST_CMP_MIN = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    // Strict compare: ties keep the earlier channel, so r beats g beats b in both modes.
    function automatic logic [W+1:0] cs_select(
        input logic         mode_min,
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] c
    );
        logic [W-1:0] v;
        logic [1:0]   idx;
        v   = a;
        idx = 2'd0;
        if (mode_min) begin
            if (b < v) begin
                v   = b;
                idx = 2'd1;
            end
            if (c < v) begin
                v   = c;
                idx = 2'd2;
            end
        end else begin
            if (b > v) begin
                v   = b;
                idx = 2'd1;
            end
            if (c > v) begin
                v   = c;
                idx = 2'd2;
            end
        end
        return {idx, v};
    endfunction

    state_t       r_state;
    logic         r_busy;
    logic [W-1:0] r_op_r;
    logic [W-1:0] r_op_g;
    logic [W-1:0] r_op_b;
    logic [U-1:0] r_op_user;
    logic [W-1:0] r_max;
    logic [1:0]   r_max_idx;
    logic         r_out_valid;
    logic [W-1:0] r_out_max;
    logic [W-1:0] r_out_min;
    logic [W-1:0] r_out_delta;
    logic [1:0]   r_out_max_idx;
    logic [1:0]   r_out_min_idx;
    logic [U-1:0] r_out_user;

    logic         w_mode_min;
    logic [W+1:0] w_sel;
    logic [W-1:0] w_sel_val;
    logic [1:0]   w_sel_idx;
    logic         w_in_ready;
    logic         w_accept;

    assign w_mode_min = (r_state == ST_CMP_MIN);
    assign w_sel      = cs_select(w_mode_min, r_op_r, r_op_g, r_op_b);
    assign w_sel_val  = w_sel[W-1:0];
    assign w_sel_idx  = w_sel[W+1:W];

    // Ready depends only on state, out_ready and reset; never on in_valid.
    assign w_in_ready = ~rst & ((r_state == ST_IDLE) |
                                ((r_state == ST_OUT) & bus.out_ready));
    assign w_accept   = w_in_ready & bus.in_valid;

    // Controller FSM with operand, intermediate and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_op_r        <= '0;
            r_op_g        <= '0;
            r_op_b        <= '0;
            r_op_user     <= '0;
            r_max         <= '0;
            r_max_idx     <= 2'd0;
            r_out_valid   <= 1'b0;
            r_out_max     <= '0;
            r_out_min     <= '0;
            r_out_delta   <= '0;
            r_out_max_idx <= 2'd0;
            r_out_min_idx <= 2'd0;
            r_out_user    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_r    <= bus.in_r;
                        r_op_g    <= bus.in_g;
                        r_op_b    <= bus.in_b;
                        r_op_user <= bus.in_user;
                        r_state   <= ST_CMP_MAX;
                        r_busy    <= 1'b1;
                    end
                end
                ST_CMP_MAX: begin
                    r_max     <= w_sel_val;
                    r_max_idx <= w_sel_idx;
                    r_state   <= ST_CMP_MIN;
                end
                ST_CMP_MIN: begin
                    // Min is always an operand and max >= min, so W bits cannot underflow.
                    r_out_max     <= r_max;
                    r_out_max_idx <= r_max_idx;
                    r_out_min     <= w_sel_val;
                    r_out_min_idx <= w_sel_idx;
                    r_out_delta   <= r_max - w_sel_val;
                    r_out_user    <= r_op_user;
                    r_out_valid   <= 1'b1;
                    r_state       <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_op_r    <= bus.in_r;
                            r_op_g    <= bus.in_g;
                            r_op_b    <= bus.in_b;
                            r_op_user <= bus.in_user;
                            r_state   <= ST_CMP_MAX;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_max     = r_out_max;
    assign bus.out_min     = r_out_min;
    assign bus.out_delta   = r_out_delta;
    assign bus.out_max_idx = r_out_max_idx;
    assign bus.out_min_idx = r_out_min_idx;
    assign bus.out_user    = r_out_user;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_rgb_minmax_ctrl.sv
// Directed self-checking bench for rgb_minmax_ctrl with hand-computed expectations.
module tb_rgb_minmax_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rgb_minmax_ctrl_if #(.W(10), .U(2)) bus ();

    rgb_minmax_ctrl #(.W(10), .U(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Streaming vectors: r, g, b, then expected max/idx, min/idx, delta; user = index % 4.
    logic [9:0] s_r     [8] = '{10'd10, 10'd100, 10'd7, 10'd0,    10'd200, 10'd400, 10'd9, 10'd1};
    logic [9:0] s_g     [8] = '{10'd20, 10'd50,  10'd7, 10'd1023, 10'd300, 10'd400, 10'd3, 10'd2};
    logic [9:0] s_b     [8] = '{10'd30, 10'd75,  10'd7, 10'd512,  10'd300, 10'd100, 10'd3, 10'd0};
    logic [9:0] s_max   [8] = '{10'd30, 10'd100, 10'd7, 10'd1023, 10'd300, 10'd400, 10'd9, 10'd2};
    logic [1:0] s_maxi  [8] = '{2'd2,   2'd0,    2'd0,  2'd1,     2'd1,    2'd0,    2'd0,  2'd1};
    logic [9:0] s_min   [8] = '{10'd10, 10'd50,  10'd7, 10'd0,    10'd200, 10'd100, 10'd3, 10'd0};
    logic [1:0] s_mini  [8] = '{2'd0,   2'd1,    2'd0,  2'd0,     2'd0,    2'd2,    2'd1,  2'd2};
    logic [9:0] s_delta [8] = '{10'd20, 10'd50,  10'd0, 10'd1023, 10'd100, 10'd300, 10'd6, 10'd2};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [9:0] emax, input logic [1:0] emaxi,
                                input logic [9:0] emin, input logic [1:0] emini,
                                input logic [9:0] edelta, input logic [1:0] euser);
        check_val({tag, "_valid"}, bus.out_valid, 1);
        check_val({tag, "_max"},   bus.out_max, emax);
        check_val({tag, "_maxi"},  bus.out_max_idx, emaxi);
        check_val({tag, "_min"},   bus.out_min, emin);
        check_val({tag, "_mini"},  bus.out_min_idx, emini);
        check_val({tag, "_delta"}, bus.out_delta, edelta);
        check_val({tag, "_user"},  bus.out_user, euser);
    endtask

    task automatic drive_pixel(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                               input logic [1:0] u);
        bus.in_r     = r;
        bus.in_g     = g;
        bus.in_b     = b;
        bus.in_user  = u;
        bus.in_valid = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pixel(input string tag, input logic [9:0] r, input logic [9:0] g,
                             input logic [9:0] b, input logic [1:0] u,
                             input logic [9:0] emax, input logic [1:0] emaxi,
                             input logic [9:0] emin, input logic [1:0] emini,
                             input logic [9:0] edelta);
        bus.out_ready = 1'b0;
        drive_pixel(r, g, b, u);
        #1;
        check_val({tag, "_idle_ready"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check_val({tag, "_cmpmax_busy"}, bus.busy, 1);
        check_val({tag, "_cmpmax_valid"}, bus.out_valid, 0);
        step();
        check_val({tag, "_cmpmin_valid"}, bus.out_valid, 0);
        step();
        check_result(tag, emax, emaxi, emin, emini, edelta, u);
        bus.out_ready = 1'b1;
        #1;
        check_val({tag, "_out_ready"}, bus.in_ready, 1);
        step();
        bus.out_ready = 1'b0;
        check_val({tag, "_done_valid"}, bus.out_valid, 0);
        check_val({tag, "_done_busy"}, bus.busy, 0);
    endtask

    initial begin
        int k;
        int res;
        int last;

        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_g      = '0;
        bus.in_b      = '0;
        bus.in_user   = '0;
        bus.out_ready = 1'b0;
        #1;
        check_val("rst_in_ready", bus.in_ready, 0);
        step();
        step();
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_busy",      bus.busy, 0);
        check_val("rst_max",       bus.out_max, 0);
        check_val("rst_min",       bus.out_min, 0);
        check_val("rst_delta",     bus.out_delta, 0);
        check_val("rst_maxi",      bus.out_max_idx, 0);
        check_val("rst_mini",      bus.out_min_idx, 0);
        check_val("rst_user",      bus.out_user, 0);
        check_val("rst_in_ready2", bus.in_ready, 0);
        rst = 1'b0;

        run_pixel("single", 10'd300, 10'd700, 10'd100, 2'd1, 10'd700, 2'd1, 10'd100, 2'd2, 10'd600);
        run_pixel("tie_a",  10'd5, 10'd5, 10'd9, 2'd2, 10'd9, 2'd2, 10'd5, 2'd0, 10'd4);
        run_pixel("tie_b",  10'd1023, 10'd0, 10'd1023, 2'd3, 10'd1023, 2'd0, 10'd0, 2'd1, 10'd1023);
        run_pixel("gray",   10'd512, 10'd512, 10'd512, 2'd0, 10'd512, 2'd0, 10'd512, 2'd0, 10'd0);

        // Backpressure: hold the first result for 5 cycles while a second pixel waits.
        bus.out_ready = 1'b0;
        drive_pixel(10'd50, 10'd60, 10'd40, 2'd1);
        step();
        drive_pixel(10'd800, 10'd200, 10'd200, 2'd2);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check_val("bp_in_ready", bus.in_ready, 0);
            check_result("bp_hold", 10'd60, 2'd1, 10'd40, 2'd2, 10'd20, 2'd1);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", bus.in_ready, 1);
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_val("bp_p2_valid0", bus.out_valid, 0);
        check_val("bp_p2_busy",   bus.busy, 1);
        step();
        check_val("bp_p2_valid1", bus.out_valid, 0);
        step();
        check_result("bp_p2", 10'd800, 2'd0, 10'd200, 2'd1, 10'd600, 2'd2);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val("bp_end_busy", bus.busy, 0);

        // Streaming: continuous in_valid with out_ready high, results every 3 cycles.
        bus.out_ready = 1'b1;
        k    = 0;
        res  = 0;
        last = 0;
        for (int c = 0; c < 60 && res < 8; c++) begin
            if (bus.out_valid) begin
                check_result("stream", s_max[res], s_maxi[res], s_min[res], s_mini[res],
                             s_delta[res], res[1:0]);
                if (res > 0) check_val("stream_gap", c - last, 3);
                last = c;
                res++;
            end
            if (k < 8) drive_pixel(s_r[k], s_g[k], s_b[k], k[1:0]);
            else bus.in_valid = 1'b0;
            #1;
            if (bus.in_valid && bus.in_ready) k++;
            step();
        end
        check_val("stream_count", res, 8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();

        // Reset during CMP_MIN discards the pixel and clears the outputs.
        drive_pixel(10'd100, 10'd200, 10'd300, 2'd1);
        step();
        bus.in_valid = 1'b0;
        step();
        check_val("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_ready", bus.in_ready, 0);
        step();
        check_val("mid_valid", bus.out_valid, 0);
        check_val("mid_busy0", bus.busy, 0);
        check_val("mid_max",   bus.out_max, 0);
        check_val("mid_min",   bus.out_min, 0);
        check_val("mid_delta", bus.out_delta, 0);
        check_val("mid_user",  bus.out_user, 0);
        rst = 1'b0;
        #1;
        check_val("mid_idle_ready", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("mid_no_valid", bus.out_valid, 0);
        end
        run_pixel("after_rst", 10'd100, 10'd200, 10'd300, 2'd1, 10'd300, 2'd2, 10'd100, 2'd0, 10'd200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
